// File: rtl/dds_phase_accum.sv
// dds_phase_accum: phase accumulator front end for a CORDIC DDS.
// Holds an AW-bit accumulator stepped by an active tuning word. The word is
// loaded through a ready/valid handshake or ramped by a linear sweep. The
// registered output is the top DW accumulator bits plus a phase offset.
// Optional feature macro: DDS_PHASE_DITHER_EN. When it is defined, a 16-bit
// LFSR adds dither below the truncation point.
module dds_phase_accum #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] ftw_in,
  input  logic          ftw_valid,
  output logic          ftw_ready,
  input  logic [DW-1:0] poff_in,
  input  logic          sweep_start,
  input  logic [AW-1:0] sweep_step,
  input  logic [AW-1:0] sweep_stop,
  output logic [DW-1:0] phase_out,
  output logic          phase_valid,
  output logic          sweeping
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWEEP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   r_ftw_cur;
  logic [AW-1:0]   w_ftw_nxt;
  logic [DW-1:0]   r_phase;
  logic            r_phase_vld;
  logic            w_ftw_rdy;
  logic            w_ftw_hs;
  logic            w_active;
  logic [AW:0]     w_sweep_sum;
  logic            w_sweep_done;
  logic [AW-1:0]   w_acc_q;

  // The accumulator only moves while the block is producing samples.
  assign w_active = (r_state == S_RUN) || (r_state == S_SWEEP);

  // A tuning-word load completes only when the state allows it.
  assign w_ftw_hs = ftw_valid & w_ftw_rdy;

  // The sweep sum carries one extra bit, so a large step cannot wrap
  // below the stop value and extend the ramp.
  assign w_sweep_sum  = {1'b0, r_ftw_cur} + {1'b0, sweep_step};
  assign w_sweep_done = (w_sweep_sum >= {1'b0, sweep_stop});

  // State register; reset forces IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake readiness. A low en always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_ftw_rdy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en)
          w_state_nxt = S_IDLE;
        else if (sweep_start && !w_ftw_hs)
          w_state_nxt = S_SWEEP;
      end
      S_SWEEP: begin
        w_ftw_rdy = 1'b0;
        if (!en)
          w_state_nxt = S_IDLE;
        else if (w_sweep_done)
          w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next active tuning word. A handshake load wins; otherwise the word
  // ramps during a sweep and is clamped at the stop value on the last step.
  // When en drops mid-sweep, the word freezes where it is.
  always_comb begin
    w_ftw_nxt = r_ftw_cur;
    if (w_ftw_hs)
      w_ftw_nxt = ftw_in;
    else if ((r_state == S_SWEEP) && en)
      w_ftw_nxt = w_sweep_done ? sweep_stop : w_sweep_sum[AW-1:0];
  end

  // Active tuning word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ftw_cur <= '0;
    else     r_ftw_cur <= w_ftw_nxt;
  end

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci feedback taps 16,14,13,11.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // The LFSR advances only on sample-producing cycles, so the dither
  // sequence is repeatable from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_lfsr <= 16'hACE1;
    else if (w_active) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  // Dither is added only to the truncated-away bits, so its mean shifts
  // the quantization error rather than the phase.
  assign w_acc_q = r_acc + AW'(r_lfsr[AW-DW-1:0]);
`else
  assign w_acc_q = r_acc;
`endif

  // Phase datapath. Each sample is taken from the accumulator before that
  // cycle's addition. A tuning-word change therefore shows up one sample
  // later with no gap. The accumulator and output hold in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_active) begin
      r_phase <= w_acc_q[AW-1:AW-DW] + poff_in;
      r_acc   <= r_acc + r_ftw_cur;
    end
  end

  // The sample strobe follows the state with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase_vld <= 1'b0;
    else     r_phase_vld <= w_active;
  end

  assign ftw_ready   = w_ftw_rdy;
  assign sweeping    = (r_state == S_SWEEP);
  assign phase_out   = r_phase;
  assign phase_valid = r_phase_vld;

endmodule

// File: tb/tb_dds_phase_accum.sv
// tb_dds_phase_accum: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a behavioural model.
module tb_dds_phase_accum;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int M_IDLE = 0, M_RUN = 1, M_SWEEP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] ftw_in;
  logic          ftw_valid;
  logic          ftw_ready;
  logic [DW-1:0] poff_in;
  logic          sweep_start;
  logic [AW-1:0] sweep_step;
  logic [AW-1:0] sweep_stop;
  logic [DW-1:0] phase_out;
  logic          phase_valid;
  logic          sweeping;

  int total = 0;
  int bad   = 0;

  dds_phase_accum #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ftw_in(ftw_in), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .poff_in(poff_in),
    .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_stop(sweep_stop),
    .phase_out(phase_out), .phase_valid(phase_valid), .sweeping(sweeping)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int            m_mode;
  logic [AW-1:0] m_acc;
  logic [AW-1:0] m_ftw;
  logic [DW-1:0] m_phase;
  logic          m_valid;
  logic          m_hs;
  logic [AW:0]   m_sum;

  assign m_hs  = ftw_valid && (m_mode != M_SWEEP);
  assign m_sum = {1'b0, m_ftw} + {1'b0, sweep_step};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE; m_acc <= '0; m_ftw <= '0; m_phase <= '0; m_valid <= 1'b0;
    end else begin
      m_valid <= (m_mode != M_IDLE);
      if (m_mode != M_IDLE) begin
        m_phase <= DW'(m_acc / 65536) + poff_in;
        m_acc   <= m_acc + m_ftw;
      end
      if (m_hs) m_ftw <= ftw_in;
      else if (en && m_mode == M_SWEEP) m_ftw <= (m_sum >= {1'b0, sweep_stop}) ? sweep_stop : m_sum[AW-1:0];
      if (!en) m_mode <= M_IDLE;
      else if (m_mode == M_IDLE) m_mode <= M_RUN;
      else if (m_mode == M_RUN && sweep_start && !m_hs) m_mode <= M_SWEEP;
      else if (m_mode == M_SWEEP && m_sum >= {1'b0, sweep_stop}) m_mode <= M_RUN;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ({phase_valid, phase_out, sweeping, ftw_ready} !==
          {m_valid, m_phase, m_mode == M_SWEEP, m_mode != M_SWEEP}) begin
        bad++;
        $display("FAIL model_cmp t=%0t got v=%b p=%h sw=%b rdy=%b want v=%b p=%h sw=%b rdy=%b",
                 $time, phase_valid, phase_out, sweeping, ftw_ready,
                 m_valid, m_phase, m_mode == M_SWEEP, m_mode != M_SWEEP);
      end
    end
  end

  // ---------------- helpers ----------------
  logic [DW-1:0] smp[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ftw_valid = 1'b0; sweep_start = 1'b0; poff_in = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_ftw(input logic [AW-1:0] w);
    ftw_in = w; ftw_valid = 1'b1;
    @(negedge clk);
    ftw_valid = 1'b0;
  endtask

  task automatic run_collect(input int n);
    repeat (n) begin
      @(negedge clk);
      if (phase_valid) smp.push_back(phase_out);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [DW-1:0] exp[]);
    chk({nm, "_count_ok"}, 32'(smp.size() >= exp.size()), 32'd1);
    foreach (exp[i])
      if (i < smp.size()) chk($sformatf("%s[%0d]", nm, i), 32'(smp[i]), 32'(exp[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nlow, nsw, nrdy;
    rst = 1'b1; en = 1'b0; ftw_in = '0; ftw_valid = 1'b0; poff_in = '0;
    sweep_start = 1'b0; sweep_step = '0; sweep_stop = '0;
    #12;
    chk("reset_phase", 32'(phase_out), 32'h0);
    chk("reset_valid", 32'(phase_valid), 32'h0);
    chk("reset_ready", 32'(ftw_ready), 32'h1);
    chk("reset_sweeping", 32'(sweeping), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Unit-step tuning word: samples count up from zero.
    load_ftw(32'h0001_0000);
    smp.delete(); en = 1'b1;
    run_collect(6);
    chk_seq("unit_step", '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004});

    // Asynchronous reset mid-run takes effect without a clock edge.
    #2 rst = 1'b1; en = 1'b0;
    #1;
    chk("async_rst_phase", 32'(phase_out), 32'h0);
    chk("async_rst_valid", 32'(phase_valid), 32'h0);
    chk("async_rst_ready", 32'(ftw_ready), 32'h1);
    chk("async_rst_sweeping", 32'(sweeping), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Quarter-turn tuning word: the phase wraps after four samples.
    load_ftw(32'h4000_0000);
    smp.delete(); en = 1'b1;
    run_collect(7);
    chk_seq("quarter_wrap", '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000});

    // Zero tuning word with an offset; en low for 3 cycles gives 3 invalid cycles.
    do_reset();
    poff_in = 16'h8000;
    load_ftw(32'h0);
    smp.delete(); en = 1'b1;
    run_collect(4);
    en = 1'b0; nlow = 0;
    repeat (3) begin @(negedge clk); if (!phase_valid) nlow++; end
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!phase_valid) nlow++; else smp.push_back(phase_out);
    end
    chk("hold_low_cycles", 32'(nlow), 32'd3);
    chk_seq("offset_hold", '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000});

    // Sweep 1 -> 4 in 0x10000 steps. A held ftw_valid is taken on the first RUN cycle.
    do_reset();
    sweep_step = 32'h0001_0000; sweep_stop = 32'h0004_0000;
    load_ftw(32'h0001_0000);
    smp.delete(); en = 1'b1; nsw = 0; nrdy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (phase_valid) smp.push_back(phase_out);
      if (sweeping) nsw++;
      if (!ftw_ready) nrdy++;
      if (c == 1) sweep_start = 1'b1;
      if (c == 2) begin sweep_start = 1'b0; ftw_valid = 1'b1; ftw_in = 32'h0010_0000; end
    end
    ftw_valid = 1'b0;
    chk("sweep_cycles", 32'(nsw), 32'd3);
    chk("sweep_ready_low", 32'(nrdy), 32'd3);
    chk_seq("sweep_phase", '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd12, 16'd28, 16'd44});

    // A handshake and sweep_start in the same cycle: load wins, no sweep.
    do_reset();
    load_ftw(32'h0001_0000);
    smp.delete(); en = 1'b1; nsw = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (phase_valid) smp.push_back(phase_out);
      if (sweeping) nsw++;
      if (c == 1) begin sweep_start = 1'b1; ftw_valid = 1'b1; ftw_in = 32'h0002_0000; end
      if (c == 2) begin sweep_start = 1'b0; ftw_valid = 1'b0; end
    end
    chk("collide_no_sweep", 32'(nsw), 32'd0);
    chk_seq("collide_phase", '{16'd0, 16'd1, 16'd2, 16'd4, 16'd6});

    // Reset in the middle of a long sweep aborts it immediately.
    do_reset();
    sweep_step = 32'h0001_0000; sweep_stop = 32'h0010_0000;
    load_ftw(32'h0001_0000);
    en = 1'b1;
    repeat (2) @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    @(negedge clk);
    chk("midsweep_sweeping", 32'(sweeping), 32'h1);
    #2 rst = 1'b1; en = 1'b0;
    #1;
    chk("sweep_rst_sweeping", 32'(sweeping), 32'h0);
    chk("sweep_rst_ready", 32'(ftw_ready), 32'h1);
    chk("sweep_rst_valid", 32'(phase_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ftw_ready), 32'h1);
    chk("post_rst_sweeping", 32'(sweeping), 32'h0);

    // Randomized traffic, checked cycle by cycle against the model.
    // Stop and tuning words stay below 2^31, so sweep sums never exceed AW bits.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 599) == 0);
      en          = ($urandom_range(0, 19) != 0);
      ftw_valid   = ($urandom_range(0, 3) == 0);
      ftw_in      = $urandom() & 32'h7FFF_FFFF;
      poff_in     = DW'($urandom());
      sweep_start = ($urandom_range(0, 11) == 0);
      if (c % 64 == 0) begin
        sweep_step = $urandom_range(1, 32'h0100_0000);
        sweep_stop = $urandom() & 32'h7FFF_FFFF;
      end
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_phase_accum.md
DDS_PHASE_ACCUM -- requirements
Module: dds_phase_accum

Interface
REQ-001 SHALL have parameter DW, default 16: output phase width; feeds the CORDIC DDS phase_in port.
REQ-002 SHALL have parameter AW, default 32: accumulator width; AW > DW and AW-DW <= 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: run enable.
REQ-006 SHALL have port ftw_in, input, AW bits: frequency tuning word.
REQ-007 SHALL have ports ftw_valid (input, 1 bit) and ftw_ready (output, 1 bit): tuning-word handshake.
REQ-008 SHALL have port poff_in, input, DW bits: phase offset, sampled every cycle.
REQ-009 SHALL have ports sweep_start (input, 1 bit), sweep_step (input, AW bits) and sweep_stop (input, AW bits): linear sweep control.
REQ-010 SHALL have port phase_out, output, DW bits: registered phase word.
REQ-011 SHALL have port phase_valid, output, 1 bit: phase_out carries a new sample.
REQ-012 SHALL have port sweeping, output, 1 bit: high while the FSM is in SWEEP.

Function
REQ-013 SHALL hold an AW-bit accumulator acc and an AW-bit active tuning word ftw_cur.
REQ-014 SHALL run an FSM with states IDLE, RUN and SWEEP; reset state is IDLE.
REQ-015 SHALL take IDLE->RUN when en=1, and RUN->IDLE or SWEEP->IDLE when en=0; en=0 has the highest priority.
REQ-016 SHALL drive ftw_ready = 1 in IDLE and RUN, and 0 in SWEEP (combinational from state).
REQ-017 SHALL load ftw_cur <= ftw_in when ftw_valid & ftw_ready; the new word is used from the next cycle's addition.
REQ-018 SHALL, in RUN, ignore sweep_start in a cycle where an ftw handshake also completes.
REQ-019 SHALL take RUN->SWEEP on sweep_start=1 when no ftw handshake completes in that cycle.
REQ-020 SHALL, in SWEEP, set ftw_cur <= ftw_cur + sweep_step each cycle while the unsigned sum < sweep_stop.
REQ-021 SHALL, in SWEEP, set ftw_cur <= sweep_stop and go to SWEEP->RUN once the sum >= sweep_stop.
REQ-022 SHALL, on SWEEP exit via en=0, leave ftw_cur at its current value.
REQ-023 SHALL, when the state is RUN or SWEEP, register phase_out <= acc[AW-1:AW-DW] + poff_in (mod 2^DW), then acc <= acc + ftw_cur (mod 2^AW, free wrap).
REQ-024 SHALL register phase_valid <= 1 when the state is RUN or SWEEP, else 0; one-cycle latency, so the first valid sample after IDLE->RUN is the pre-addition acc.
REQ-025 SHALL freeze acc and phase_out in IDLE; re-entering RUN resumes from the held acc (phase-continuous).
REQ-026 SHALL leave phase_out's timing unaffected when ftw_cur changes (no glitch cycles).

Reset
REQ-027 SHALL, while rst=1, asynchronously clear acc, phase_out, phase_valid, sweeping and ftw_cur to 0 and force state IDLE.
REQ-028 SHALL, when rst asserts mid-sweep, abort the sweep; the first cycle after release is IDLE with ftw_ready=1.

Configuration
REQ-029 SHALL support macro DDS_PHASE_DITHER_EN; when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; advances each RUN/SWEEP cycle) adds lfsr[AW-DW-1:0] to acc before truncation in REQ-023.
REQ-030 SHALL, when DDS_PHASE_DITHER_EN is undefined, use plain truncation and instantiate no LFSR logic.

Verification (DW=16, AW=32, dither off unless stated)
REQ-031 SHALL cover: rst pulse mid-run -> phase_out=0x0000, phase_valid=0, ftw_ready=1, sweeping=0 immediately, without waiting for a clock edge.
REQ-032 SHALL cover: ftw=0x0001_0000 loaded, poff=0, en=1 -> phase_valid samples 0x0000, 0x0001, 0x0002, ...
REQ-033 SHALL cover: ftw=0x4000_0000 -> samples 0x0000, 0x4000, 0x8000, 0xC000, 0x0000 (wrap).
REQ-034 SHALL cover: ftw=0, poff=0x8000 -> constant 0x8000; en low 3 cycles then high -> phase_valid low 3 cycles, samples continue from the held value.
REQ-035 SHALL cover: ftw=0x0001_0000, step=0x0001_0000, stop=0x0004_0000, sweep_start pulse -> ftw_cur takes 2, 3, 4 (x0x10000) on successive cycles; sweeping high 3 cycles; ftw_ready low during the sweep; ftw_valid held high throughout is accepted on the first RUN cycle.
REQ-036 SHALL cover: ftw_valid and sweep_start asserted in the same RUN cycle -> the ftw is loaded, the state stays RUN and sweeping stays 0.
